// File: rtl/adc_serial_reader.sv
// adc_serial_reader: drives a TLC549-style 8-bit serial ADC (CS_n, SCLK,
// DOUT MSB first) and presents each conversion as a parallel byte with a
// one-cycle valid strobe. Transfers run single-shot on a start pulse or
// free-running every SAMPLE_PERIOD clocks while auto_en is high.
//
// Optional build macro ADC_AVG_EN: when defined, adc_value is the 4-sample
// moving average (sum of the last four raw samples >> 2, truncated) instead
// of the raw sample. Undefined (default): raw sample, no history registers.
//
// Interface handshake: there is no backpressure. adc_valid is a single-cycle
// strobe, high exactly in the cycle adc_value takes a new capture; adc_value
// then holds until the next capture. start is only looked at while busy is
// low; a start seen while busy is dropped, never queued.
`timescale 1ns/1ps
module adc_serial_reader #(
  parameter int CLK_DIV       = 27,
  parameter int CS_SETUP      = 81,
  parameter int CONV_WAIT     = 1080,
  parameter int SAMPLE_PERIOD = 54000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic       adc_dout,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [7:0] adc_value,
  output logic       adc_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_CONV  = 2'd3
  } state_t;

  // One shared phase counter serves SETUP, each SCLK half-period and CONV.
  localparam int CNT_MAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CNT_MAX  = (CNT_MAX0 > CONV_WAIT) ? CNT_MAX0 : CONV_WAIT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int TMR_W    = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_WAIT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SAMPLE_PERIOD - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       value_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic             valid_q;
  logic             busy_q;
  logic             pending_q;
  logic [1:0]       sync_q;
  logic [TMR_W-1:0] timer_q;

  logic             tick;
  logic             din;
  logic             phase_end;
  logic             capture;
  logic [7:0]       capture_d;

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign adc_value = value_q;
  assign adc_valid = valid_q;
  assign busy      = busy_q;

  assign din       = sync_q[1];
  assign tick      = auto_en && (timer_q == TMR_LAST);
  assign phase_end = (cnt_q == DIV_LAST);
  // Last clk of the 8th low phase: the byte is complete and gets published.
  assign capture   = (state_q == S_SHIFT) && phase_end && !sclk_q &&
                     (bit_cnt_q == 3'd7);

  // Two-flop synchroniser for the asynchronous ADC data line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], adc_dout};
  end

  // Sample-period timer: wraps at SAMPLE_PERIOD-1, parked at 0 when auto is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                timer_q <= '0;
    else if (!auto_en || tick) timer_q <= '0;
    else                      timer_q <= timer_q + TMR_W'(1);
  end

`ifdef ADC_AVG_EN
  logic [7:0] hist_q [4];
  logic [9:0] avg_sum_d;

  // After the shift the four history slots hold the new sample plus the
  // three previous ones, so the average is formed from those directly.
  always_comb begin
    avg_sum_d = 10'(shift_q) + 10'(hist_q[0]) + 10'(hist_q[1]) +
                10'(hist_q[2]);
  end

  assign capture_d = avg_sum_d[9:2];

  // Moving-average history, shifted once per capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q[0] <= 8'h00;
      hist_q[1] <= 8'h00;
      hist_q[2] <= 8'h00;
      hist_q[3] <= 8'h00;
    end else if (capture) begin
      hist_q[0] <= shift_q;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      hist_q[3] <= hist_q[2];
    end
  end
`else
  assign capture_d = shift_q;
`endif

  // Transfer FSM with registered CS_n/SCLK/value/valid/busy and the
  // one-deep pending-tick flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      value_q   <= 8'h00;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // A tick that arrives while a transfer is running is remembered once.
      if (!auto_en)                         pending_q <= 1'b0;
      else if (tick && (state_q != S_IDLE)) pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          cs_n_q <= 1'b1;
          sclk_q <= 1'b0;
          if (start || pending_q || tick) begin
            state_q   <= S_SETUP;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            pending_q <= 1'b0;
          end
        end

        S_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            state_q   <= S_SHIFT;
            cnt_q     <= '0;
            sclk_q    <= 1'b1;
            bit_cnt_q <= 3'd0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_SHIFT: begin
          if (phase_end) begin
            cnt_q <= '0;
            if (sclk_q) begin
              shift_q <= {shift_q[6:0], din};
              sclk_q  <= 1'b0;
            end else if (capture) begin
              value_q <= capture_d;
              valid_q <= 1'b1;
              cs_n_q  <= 1'b1;
              state_q <= S_CONV;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              sclk_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_CONV: begin
          if (cnt_q == CONV_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader with short timing parameters
// (CLK_DIV=2, CS_SETUP=3, CONV_WAIT=5, SAMPLE_PERIOD=100).
// Cycle labels: a start driven high in cycle c is sampled at the following
// edge; CS_n falls in cycle c+1, SCLK first rises in c+4, adc_valid in c+36,
// busy falls in c+41.
`timescale 1ns/1ps
module tb_adc_serial_reader;

  localparam int CLK_DIV       = 2;
  localparam int CS_SETUP      = 3;
  localparam int CONV_WAIT     = 5;
  localparam int SAMPLE_PERIOD = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       auto_en;
  logic       adc_dout;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [7:0] adc_value;
  logic       adc_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_serial_reader #(
    .CLK_DIV(CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CONV_WAIT(CONV_WAIT),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .auto_en(auto_en),
    .adc_dout(adc_dout),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_value(adc_value),
    .adc_valid(adc_valid),
    .busy(busy)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ADC model: MSB after CS_n falls, next bit per SCLK fall
  logic [7:0] adc_data = 8'h00;
  logic [2:0] bit_idx  = 3'd7;

  assign adc_dout = adc_data[bit_idx];

  always @(negedge adc_cs_n) begin
    bit_idx = 3'd7;
    while (!adc_cs_n) begin
      @(negedge adc_sclk or posedge adc_cs_n);
      if (!adc_cs_n && bit_idx != 3'd0) bit_idx = bit_idx - 3'd1;
    end
  end

  // ---------------- monitor (samples on the falling clock edge) ----------
  logic p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0;
  int   n_valid = 0, n_cs_fall = 0, bad_width = 0;
  int   valid_cyc = -1, cs_fall_cyc = -1, cs_rise_cyc = -1;
  int   busy_rise_cyc = -1, busy_fall_cyc = -1, first_sclk_cyc = -1;
  int   sclk_in_xfer = 0, hi_len = 0, lo_len = 0;
  logic [7:0] valid_val = 8'h00;
  int   cs_fall_q[$];

  always @(negedge clk) begin
    if (adc_valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
      valid_val = adc_value;
    end
    if (p_cs && !adc_cs_n) begin
      cs_fall_cyc = cyc;
      n_cs_fall++;
      cs_fall_q.push_back(cyc);
      sclk_in_xfer = 0;
      lo_len = 0;
    end
    if (!p_cs && adc_cs_n) begin
      cs_rise_cyc = cyc;
      if (sclk_in_xfer == 8 && lo_len != 2) bad_width++;
    end
    if (!p_sclk && adc_sclk) begin
      if (sclk_in_xfer > 0 && lo_len != 2) bad_width++;
      sclk_in_xfer++;
      if (sclk_in_xfer == 1) first_sclk_cyc = cyc;
      hi_len = 0;
      lo_len = 0;
    end
    if (p_sclk && !adc_sclk) begin
      if (hi_len != 2) bad_width++;
      hi_len = 0;
      lo_len = 0;
    end
    if (!p_busy && busy) busy_rise_cyc = cyc;
    if (p_busy && !busy) busy_fall_cyc = cyc;
    if (adc_sclk) hi_len++;
    else if (!adc_cs_n) lo_len++;
    p_cs   = adc_cs_n;
    p_sclk = adc_sclk;
    p_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int c);
    @(posedge clk);
    #1 start = 1'b1;
    c = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
    checks++; if (adc_value !== 8'h00) begin errors++; $display("FAIL reset_value: got %h expected 00", adc_value); end
    checks++; if (adc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", adc_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single(input logic [7:0] data);
    int c, nv0, bw0;
    bit ok;
    adc_data = data;
    nv0 = n_valid;
    bw0 = bad_width;
    pulse_start(c);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: busy still %b expected 0", busy); end
    checks++; if (n_valid - nv0 != 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", n_valid - nv0); end
    checks++; if (valid_val !== data) begin errors++; $display("FAIL single_value: got %h expected %h", valid_val, data); end
    checks++; if (valid_cyc != c + 36) begin errors++; $display("FAIL single_latency: got %0d expected %0d", valid_cyc - c, 36); end
    checks++; if (cs_fall_cyc != c + 1) begin errors++; $display("FAIL single_cs_fall: got %0d expected 1", cs_fall_cyc - c); end
    checks++; if (first_sclk_cyc != c + 4) begin errors++; $display("FAIL single_cs_setup: got %0d expected 4", first_sclk_cyc - c); end
    checks++; if (sclk_in_xfer != 8) begin errors++; $display("FAIL single_sclk_pulses: got %0d expected 8", sclk_in_xfer); end
    checks++; if (bad_width != bw0) begin errors++; $display("FAIL single_sclk_width: got %0d bad phases expected 0", bad_width - bw0); end
    checks++; if (cs_rise_cyc != c + 36) begin errors++; $display("FAIL single_cs_rise: got %0d expected 36", cs_rise_cyc - c); end
    checks++; if (busy_rise_cyc != c + 1) begin errors++; $display("FAIL single_busy_rise: got %0d expected 1", busy_rise_cyc - c); end
    checks++; if (busy_fall_cyc != c + 41) begin errors++; $display("FAIL single_busy_fall: got %0d expected 41", busy_fall_cyc - c); end
    repeat (20) @(negedge clk);
    checks++; if (adc_value !== data) begin errors++; $display("FAIL single_hold: got %h expected %h", adc_value, data); end
  endtask

  task automatic test_boundary;
    test_single(8'h00);
    test_single(8'hFF);
    test_single(8'h01);
    test_single(8'h80);
  endtask

  task automatic test_start_while_busy;
    int c, c2, c3, nv0, nf0;
    bit ok;
    adc_data = 8'h69;
    nv0 = n_valid;
    nf0 = n_cs_fall;
    pulse_start(c);
    repeat (8) @(posedge clk);
    pulse_start(c2);
    repeat (25) @(posedge clk);
    pulse_start(c3);
    wait_idle(ok);
    repeat (60) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout: busy %b expected 0", busy); end
    checks++; if (n_valid - nv0 != 1) begin errors++; $display("FAIL busy_start_valid_count: got %0d expected 1 (starts at +%0d,+%0d)", n_valid - nv0, c2 - c, c3 - c); end
    checks++; if (n_cs_fall - nf0 != 1) begin errors++; $display("FAIL busy_start_transfers: got %0d expected 1", n_cs_fall - nf0); end
    checks++; if (adc_value !== 8'h69) begin errors++; $display("FAIL busy_start_value: got %h expected 69", adc_value); end
  endtask

  task automatic test_auto;
    int nv0, nf0, bad_gap;
    bit ok;
    adc_data = 8'h3C;
    nv0 = n_valid;
    nf0 = n_cs_fall;
    @(posedge clk);
    #1 auto_en = 1'b1;
    repeat (1000) @(posedge clk);
    #1 auto_en = 1'b0;
    wait_idle(ok);
    repeat (300) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL auto_timeout: busy %b expected 0", busy); end
    checks++; if (n_cs_fall - nf0 != 10) begin errors++; $display("FAIL auto_transfers: got %0d expected 10", n_cs_fall - nf0); end
    checks++; if (n_valid - nv0 != 10) begin errors++; $display("FAIL auto_valid_count: got %0d expected 10", n_valid - nv0); end
    bad_gap = 0;
    for (int i = nf0 + 1; i < n_cs_fall; i++)
      if (cs_fall_q[i] - cs_fall_q[i-1] != 100) bad_gap++;
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL auto_spacing: got %0d gaps not 100 expected 0", bad_gap); end
    checks++; if (adc_value !== 8'h3C) begin errors++; $display("FAIL auto_value: got %h expected 3c", adc_value); end
  endtask

  task automatic test_reset_mid;
    int c, nv0;
    adc_data = 8'h77;
    nv0 = n_valid;
    pulse_start(c);
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL midreset_cs_n: got %b expected 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b0) begin errors++; $display("FAIL midreset_sclk: got %b expected 0", adc_sclk); end
    checks++; if (adc_value !== 8'h00) begin errors++; $display("FAIL midreset_value: got %h expected 00", adc_value); end
    checks++; if (adc_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", adc_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (n_valid != nv0) begin errors++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", n_valid - nv0); end
    checks++; if (adc_value !== 8'h00) begin errors++; $display("FAIL midreset_value_after: got %h expected 00", adc_value); end
    test_single(8'h5A);
  endtask

`ifdef ADC_AVG_EN
  task automatic test_avg;
    logic [7:0] raw [4];
    logic [7:0] avg [4];
    int c;
    bit ok;
    raw[0] = 8'h10; raw[1] = 8'h20; raw[2] = 8'h30; raw[3] = 8'h40;
    avg[0] = 8'h04; avg[1] = 8'h0C; avg[2] = 8'h18; avg[3] = 8'h28;
    for (int i = 0; i < 4; i++) begin
      adc_data = raw[i];
      pulse_start(c);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL avg_timeout: busy %b expected 0", busy); end
      checks++; if (adc_value !== avg[i]) begin errors++; $display("FAIL avg_value_%0d: got %h expected %h", i, adc_value, avg[i]); end
      checks++; if (valid_cyc != c + 36) begin errors++; $display("FAIL avg_latency_%0d: got %0d expected 36", i, valid_cyc - c); end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    auto_en = 1'b0;
    test_reset;
`ifdef ADC_AVG_EN
    test_avg;
`else
    test_single(8'hA5);
    test_boundary;
    test_start_while_busy;
    test_auto;
    test_reset_mid;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
